// File: rtl/conv_ifft_collector_pkg.sv
// Shared definitions for the conv-layer IFFT collector and its banks.
// Holds cacheline geometry, the fill-side state type and the common
// complex sample type used across the conv datapath.
package conv_ifft_collector_pkg;

    localparam int CL_W     = 512;
    localparam int CL_BEATS = 4;
    localparam int BEAT_W   = 2;

    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
    } complex_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } collect_state_t;

endpackage

// File: rtl/conv_ifft_collector_cl_bank.sv
// One burst buffer: 4 x CL_W beats with a full flag and a read-beat mux.
// Ports: beat write (wr_en/wr_beat/wr_dat), full set/clear, synchronous
// clear of the flag (clr), combinational read of beat rd_beat.
module cl_bank
    import conv_ifft_collector_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [BEAT_W-1:0] wr_beat,
    input  logic [CL_W-1:0]   wr_dat,
    input  logic              set_full,
    input  logic              clr_full,
    input  logic [BEAT_W-1:0] rd_beat,
    output logic              full,
    output logic [CL_W-1:0]   rd_dat
);

    logic [CL_W-1:0] mem_q [CL_BEATS];
    logic [CL_W-1:0] mem_d [CL_BEATS];
    logic            full_q;
    logic            full_d;

    always_comb begin
        mem_d  = mem_q;
        full_d = full_q;
        if (wr_en) begin
            mem_d[wr_beat] = wr_dat;
        end
        // The collector never fills and drains the same bank in one cycle,
        // so the order of set/clear here only matters for clr.
        if (clr) begin
            full_d = 1'b0;
        end else if (clr_full) begin
            full_d = 1'b0;
        end else if (set_full) begin
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CL_BEATS; i++) begin
                mem_q[i] <= '0;
            end
            full_q <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            full_q <= full_d;
        end
    end

    assign full   = full_q;
    assign rd_dat = mem_q[rd_beat];

endmodule

// File: rtl/conv_ifft_collector.sv
// Double-buffers 4-beat IFFT bursts and streams them out as addressed writes.
// Ports: start/base_addr/num_bursts job setup; in_valid/cacheline_in burst in;
// wr_valid/wr_ready/wr_addr/wr_data write out; busy/done/err_* status.
module conv_ifft_collector
    import conv_ifft_collector_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_bursts,
    input  logic              in_valid,
    input  logic [CL_W-1:0]   cacheline_in,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [CL_W-1:0]   wr_data,
    output logic              busy,
    output logic              done,
    output logic              err_short,
    output logic              err_overflow
);

    collect_state_t    state_q, state_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              discard_q, discard_d;
    logic              fill_ptr_q, fill_ptr_d;
    logic              err_short_q, err_short_d;
    logic              err_ovf_q, err_ovf_d;
    logic              fill_we, fill_done;

    logic              drain_ptr_q, drain_ptr_d;
    logic [BEAT_W-1:0] drain_beat_q, drain_beat_d;
    logic [CNT_W-1:0]  burst_done_q, burst_done_d;
    logic [CNT_W-1:0]  num_bursts_q, num_bursts_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              drain_done;

    logic [1:0]        bank_full;
    logic [CL_W-1:0]   bank_rd [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        cl_bank u_bank (
            .clk      (clk),
            .reset_n  (reset_n),
            .clr      (start),
            .wr_en    (fill_we && (fill_ptr_q == 1'(b))),
            .wr_beat  (beat_cnt_q),
            .wr_dat   (cacheline_in),
            .set_full (fill_done && (fill_ptr_q == 1'(b))),
            .clr_full (drain_done && (drain_ptr_q == 1'(b))),
            .rd_beat  (drain_beat_q),
            .full     (bank_full[b]),
            .rd_dat   (bank_rd[b])
        );
    end

    // Fill side. An overflowing burst still walks through FILL with
    // discard set so the ignored beats are counted and we resync on beat 3.
    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        discard_d   = discard_q;
        fill_ptr_d  = fill_ptr_q;
        err_short_d = err_short_q;
        err_ovf_d   = err_ovf_q;
        fill_we     = 1'b0;
        fill_done   = 1'b0;
        if (start) begin
            state_d     = IDLE;
            beat_cnt_d  = '0;
            discard_d   = 1'b0;
            fill_ptr_d  = 1'b0;
            err_short_d = 1'b0;
            err_ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        state_d    = FILL;
                        beat_cnt_d = 2'd1;
                        if (!bank_full[fill_ptr_q]) begin
                            fill_we   = 1'b1;
                            discard_d = 1'b0;
                        end else begin
                            err_ovf_d = 1'b1;
                            discard_d = 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_valid) begin
                        fill_we = !discard_q;
                        if (beat_cnt_q == 2'(CL_BEATS - 1)) begin
                            state_d    = IDLE;
                            beat_cnt_d = '0;
                            if (!discard_q) begin
                                fill_done  = 1'b1;
                                fill_ptr_d = !fill_ptr_q;
                            end
                        end else begin
                            beat_cnt_d = beat_cnt_q + 2'd1;
                        end
                    end else begin
                        // Partial bank is abandoned; its full flag never set.
                        err_short_d = 1'b1;
                        state_d     = IDLE;
                        beat_cnt_d  = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Drain side and job tracking.
    always_comb begin
        drain_ptr_d   = drain_ptr_q;
        drain_beat_d  = drain_beat_q;
        burst_done_d  = burst_done_q;
        num_bursts_d  = num_bursts_q;
        base_d        = base_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        drain_done    = 1'b0;
        if (start) begin
            drain_ptr_d  = 1'b0;
            drain_beat_d = '0;
            burst_done_d = '0;
            num_bursts_d = num_bursts;
            base_d       = base_addr;
            busy_d       = (num_bursts != '0);
            done_d       = (num_bursts == '0);
        end else if (wr_valid && wr_ready) begin
            if (drain_beat_q == 2'(CL_BEATS - 1)) begin
                drain_beat_d = '0;
                drain_done   = 1'b1;
                drain_ptr_d  = !drain_ptr_q;
                burst_done_d = burst_done_q + 1'b1;
                if (busy_q && (burst_done_d == num_bursts_q)) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end
            end else begin
                drain_beat_d = drain_beat_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            discard_q    <= 1'b0;
            fill_ptr_q   <= 1'b0;
            err_short_q  <= 1'b0;
            err_ovf_q    <= 1'b0;
            drain_ptr_q  <= 1'b0;
            drain_beat_q <= '0;
            burst_done_q <= '0;
            num_bursts_q <= '0;
            base_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            discard_q    <= discard_d;
            fill_ptr_q   <= fill_ptr_d;
            err_short_q  <= err_short_d;
            err_ovf_q    <= err_ovf_d;
            drain_ptr_q  <= drain_ptr_d;
            drain_beat_q <= drain_beat_d;
            burst_done_q <= burst_done_d;
            num_bursts_q <= num_bursts_d;
            base_q       <= base_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign wr_valid     = bank_full[drain_ptr_q];
    assign wr_data      = bank_rd[drain_ptr_q];
    assign wr_addr      = base_q + (ADDR_W'(burst_done_q) << 2) + ADDR_W'(drain_beat_q);
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_short    = err_short_q;
    assign err_overflow = err_ovf_q;

endmodule

// File: tb/tb_conv_ifft_collector.sv
module tb_conv_ifft_collector;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         start = 1'b0;
    logic [31:0]  base_addr = '0;
    logic [15:0]  num_bursts = '0;
    logic         in_valid = 1'b0;
    logic [511:0] cacheline_in = '0;
    logic         wr_valid;
    logic         wr_ready = 1'b0;
    logic [31:0]  wr_addr;
    logic [511:0] wr_data;
    logic         busy, done, err_short, err_overflow;

    int n_chk = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [31:0]  cap_addr [$];
    logic [511:0] cap_data [$];

    conv_ifft_collector #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .num_bursts(num_bursts), .in_valid(in_valid), .cacheline_in(cacheline_in),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err_short(err_short), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         st;
        logic [31:0]  base;
        logic [15:0]  nb;
        logic         iv;
        logic [511:0] din;
        logic         rdy;
        logic         e_vld;
        logic [31:0]  e_addr;
        logic [511:0] e_data;
        logic         e_busy;
        logic         e_done;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [511:0] mk(input logic [31:0] s);
        return {16{s}};
    endfunction

    function automatic vec_t row(input logic st, input logic [31:0] b, input logic [15:0] n,
                                 input logic iv, input logic [511:0] d, input logic rdy,
                                 input logic ev, input logic [31:0] ea, input logic [511:0] ed,
                                 input logic eb, input logic edn);
        vec_t r;
        r.st = st; r.base = b; r.nb = n; r.iv = iv; r.din = d; r.rdy = rdy;
        r.e_vld = ev; r.e_addr = ea; r.e_data = ed; r.e_busy = eb; r.e_done = edn;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drives one cycle of inputs, records any handshake taken at the coming edge.
    task automatic step(input logic iv, input logic [511:0] d, input logic rdy);
        start = 1'b0;
        in_valid = iv;
        cacheline_in = d;
        wr_ready = rdy;
        if (wr_valid && wr_ready) begin
            cap_addr.push_back(wr_addr);
            cap_data.push_back(wr_data);
        end
        @(negedge clk);
        if (done) done_cnt++;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [15:0] n);
        start = 1'b1; base_addr = b; num_bursts = n; in_valid = 1'b0; wr_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        cap_addr.delete();
        cap_data.delete();
    endtask

    task automatic send_burst(input logic [31:0] tag, input logic rdy);
        for (int k = 0; k < 4; k++) step(1'b1, mk(tag + 32'(k)), rdy);
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1);
    endtask

    task automatic check_lines(input string nm, input int off, input int n,
                               input logic [31:0] a0, input logic [31:0] t0);
        for (int k = 0; k < n; k++) begin
            if (off + k < cap_addr.size()) begin
                chk($sformatf("%s_addr%0d", nm, k), 512'(cap_addr[off+k]), 512'(a0 + 32'(k)));
                chk($sformatf("%s_data%0d", nm, k), cap_data[off+k], mk(t0 + 32'(k)));
            end
        end
    endtask

    task automatic run_table(input string nm);
        for (int i = 0; i < 11; i++) begin
            chk($sformatf("%s%0d_vld", nm, i), 512'(wr_valid), 512'(tbl[i].e_vld));
            chk($sformatf("%s%0d_busy", nm, i), 512'(busy), 512'(tbl[i].e_busy));
            chk($sformatf("%s%0d_done", nm, i), 512'(done), 512'(tbl[i].e_done));
            if (tbl[i].e_vld) begin
                chk($sformatf("%s%0d_addr", nm, i), 512'(wr_addr), 512'(tbl[i].e_addr));
                chk($sformatf("%s%0d_data", nm, i), wr_data, tbl[i].e_data);
            end
            start = tbl[i].st; base_addr = tbl[i].base; num_bursts = tbl[i].nb;
            in_valid = tbl[i].iv; cacheline_in = tbl[i].din; wr_ready = tbl[i].rdy;
            @(negedge clk);
        end
        start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    endtask

    logic         stalled;
    logic         rdy_t;
    logic [31:0]  pa;
    logic [511:0] pd;

    initial begin
        // Single burst at base 0x100, one-cycle fill-to-valid latency.
        tbl[0]  = row(1, 32'h100, 16'd1, 0, '0,         0, 0, 0,          '0,        0, 0);
        tbl[1]  = row(0, 32'h100, 16'd1, 1, mk(32'h10), 0, 0, 0,          '0,        1, 0);
        tbl[2]  = row(0, 32'h100, 16'd1, 1, mk(32'h11), 0, 0, 0,          '0,        1, 0);
        tbl[3]  = row(0, 32'h100, 16'd1, 1, mk(32'h12), 0, 0, 0,          '0,        1, 0);
        tbl[4]  = row(0, 32'h100, 16'd1, 1, mk(32'h13), 0, 0, 0,          '0,        1, 0);
        tbl[5]  = row(0, 32'h100, 16'd1, 0, '0,         1, 1, 32'h100, mk(32'h10), 1, 0);
        tbl[6]  = row(0, 32'h100, 16'd1, 0, '0,         1, 1, 32'h101, mk(32'h11), 1, 0);
        tbl[7]  = row(0, 32'h100, 16'd1, 0, '0,         1, 1, 32'h102, mk(32'h12), 1, 0);
        tbl[8]  = row(0, 32'h100, 16'd1, 0, '0,         1, 1, 32'h103, mk(32'h13), 1, 0);
        tbl[9]  = row(0, 32'h100, 16'd1, 0, '0,         1, 0, 0,          '0,        0, 1);
        tbl[10] = row(0, 32'h100, 16'd1, 0, '0,         0, 0, 0,          '0,        0, 0);

        repeat (2) @(negedge clk);
        chk("rst_vld", 512'(wr_valid), 512'(0));
        chk("rst_addr", 512'(wr_addr), 512'(0));
        chk("rst_data", wr_data, '0);
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_eshort", 512'(err_short), 512'(0));
        chk("rst_eovf", 512'(err_overflow), 512'(0));
        reset_n = 1'b1;
        @(negedge clk);

        run_table("single");

        // Zero-length job completes immediately.
        do_start(32'h0, 16'd0);
        chk("zero_done", 512'(done), 512'(1));
        chk("zero_busy", 512'(busy), 512'(0));
        step(0, '0, 0);
        chk("zero_done_pulse", 512'(done), 512'(0));

        // Back-to-back bursts held by back-pressure.
        do_start(32'h200, 16'd2);
        send_burst(32'h20, 0);
        send_burst(32'h24, 0);
        chk("b2b_eovf", 512'(err_overflow), 512'(0));
        chk("b2b_eshort", 512'(err_short), 512'(0));
        chk("b2b_vld", 512'(wr_valid), 512'(1));
        step(0, '0, 0);
        chk("b2b_hold_addr", 512'(wr_addr), 512'(32'h200));
        drain(10);
        chk("b2b_count", 512'(cap_addr.size()), 512'(8));
        check_lines("b2b", 0, 8, 32'h200, 32'h20);
        chk("b2b_done", 512'(done_cnt), 512'(1));
        chk("b2b_busy", 512'(busy), 512'(0));

        // Third burst with both banks full is dropped; fourth is accepted.
        do_start(32'h300, 16'd3);
        send_burst(32'h30, 0);
        send_burst(32'h34, 0);
        send_burst(32'h38, 0);
        chk("ovf_flag", 512'(err_overflow), 512'(1));
        chk("ovf_eshort", 512'(err_short), 512'(0));
        drain(10);
        chk("ovf_count8", 512'(cap_addr.size()), 512'(8));
        check_lines("ovf", 0, 8, 32'h300, 32'h30);
        send_burst(32'h50, 1);
        drain(6);
        chk("ovf_count12", 512'(cap_addr.size()), 512'(12));
        check_lines("ovf4", 8, 4, 32'h308, 32'h50);
        chk("ovf_done", 512'(done_cnt), 512'(1));
        chk("ovf_sticky", 512'(err_overflow), 512'(1));

        // Short burst is discarded; next full burst lands at base+0.
        do_start(32'h400, 16'd1);
        chk("short_eovf_clr", 512'(err_overflow), 512'(0));
        step(1, mk(32'h60), 0);
        step(1, mk(32'h61), 0);
        step(0, '0, 0);
        step(0, '0, 1);
        step(0, '0, 1);
        chk("short_flag", 512'(err_short), 512'(1));
        chk("short_novld", 512'(wr_valid), 512'(0));
        chk("short_nocap", 512'(cap_addr.size()), 512'(0));
        send_burst(32'h70, 1);
        drain(6);
        chk("short_count", 512'(cap_addr.size()), 512'(4));
        check_lines("short", 0, 4, 32'h400, 32'h70);
        chk("short_done", 512'(done_cnt), 512'(1));

        // Toggling ready: outputs hold while stalled, each line once.
        do_start(32'h500, 16'd2);
        chk("tog_eshort_clr", 512'(err_short), 512'(0));
        send_burst(32'h80, 0);
        send_burst(32'h84, 0);
        stalled = 1'b0; pa = '0; pd = '0;
        for (int i = 0; i < 24; i++) begin
            if (stalled) begin
                chk($sformatf("tog_hold_addr%0d", i), 512'(wr_addr), 512'(pa));
                chk($sformatf("tog_hold_data%0d", i), wr_data, pd);
            end
            rdy_t = 1'(i % 2);
            stalled = wr_valid && !rdy_t;
            pa = wr_addr;
            pd = wr_data;
            step(0, '0, rdy_t);
        end
        chk("tog_count", 512'(cap_addr.size()), 512'(8));
        check_lines("tog", 0, 8, 32'h500, 32'h80);
        chk("tog_done", 512'(done_cnt), 512'(1));

        // Reset during drain beat 2, then the single-burst case again.
        do_start(32'h600, 16'd1);
        send_burst(32'h90, 0);
        for (int i = 0; i < 10; i++) begin
            if (wr_valid && wr_addr == 32'h602) break;
            step(0, '0, 1);
        end
        chk("rst2_reached", 512'(wr_addr), 512'(32'h602));
        #2 reset_n = 1'b0;
        #1;
        chk("rst2_vld", 512'(wr_valid), 512'(0));
        chk("rst2_addr", 512'(wr_addr), 512'(0));
        chk("rst2_data", wr_data, '0);
        chk("rst2_busy", 512'(busy), 512'(0));
        @(negedge clk);
        step(0, '0, 1);
        step(0, '0, 1);
        chk("rst2_nodone", 512'(done_cnt), 512'(0));
        reset_n = 1'b1;
        run_table("again");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_ifft_collector.md
# conv_ifft_collector

Receives the 4-beat cacheline bursts produced by the IFFT stage of the conv layer and hands them to the memory write path as a throttled, addressed stream. The IFFT stage emits each 4-cacheline result on 4 consecutive cycles and cannot stall, so this block double-buffers whole bursts and absorbs write-path back-pressure. It also generates write addresses, tracks job completion, and flags protocol errors.

## Interface
- ADDR_W, 32, cacheline-granular write address width
- CNT_W, 16, width of the burst counter and of `num_bursts`
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; latches `base_addr` and `num_bursts`, clears counters and error flags
- base_addr  in  ADDR_W  first cacheline address of the job
- num_bursts  in  CNT_W  bursts in the job; 0 means the job completes immediately
- in_valid  in  1  IFFT output valid; high for exactly 4 consecutive cycles per burst
- cacheline_in  in  512  IFFT beat data; beat k carries output tile k
- wr_valid  out  1  write request valid
- wr_ready  in  1  write path accepts the request
- wr_addr  out  ADDR_W  write address
- wr_data  out  512  write data
- busy  out  1  job active (from `start` until `done`)
- done  out  1  one-cycle pulse after the last cacheline of the job is accepted
- err_short  out  1  sticky; `in_valid` dropped mid-burst
- err_overflow  out  1  sticky; a burst arrived while both banks were full

## Operation
- Two banks, each holding 4 x 512 bits plus a full flag. Banks fill and drain in ping-pong order.
- Fill side has 2 states:
  - IDLE: on `in_valid` with a free bank, write beat 0 and go to FILL with beat_cnt=1.
  - FILL: each `in_valid` cycle writes the next beat. When beat 3 is written, set the bank full, toggle the fill pointer, and return to IDLE.
- Short burst: `in_valid` low in FILL sets `err_short`, discards the partial bank (it stays empty), and returns to IDLE.
- Overflow: `in_valid` in IDLE with no free bank sets `err_overflow`. The whole 4-beat burst is ignored, and ignored beats are counted so that resync happens after beat 3.
- Drain side:
  - `wr_valid` = the drain bank is full.
  - `wr_data` = drain bank[drain_beat].
  - `wr_addr` = base + 4*burst_done + drain_beat.
  - On `wr_valid && wr_ready`, advance drain_beat. At beat 3, clear the bank's full flag, toggle the drain pointer, and increment burst_done.
- When burst_done reaches `num_bursts`: pulse `done`, drop `busy`.
- Bursts arriving while `busy` is low are still buffered and drained. Address arithmetic wraps modulo 2^ADDR_W.
- `start` while `busy`: the job restarts. Counters, errors and both banks are cleared, and any in-flight fill is abandoned.

## Timing
- Reset values: `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0, both error flags 0, both banks empty, fill state IDLE.
- Latency: if beat 3 is written at cycle t, `wr_valid` is high at t+1. Drain rate is 1 cacheline per cycle when `wr_ready` is held high.
- `wr_addr`/`wr_data` hold stable while `wr_valid && !wr_ready`.
- Simultaneous fill-complete and drain-complete on the same bank index cannot occur. Fill-complete on one bank and drain-complete on the other in the same cycle are both honoured.
- A bank freed at cycle t may be filled by a burst starting at t+1. A burst starting at t sees the bank as full, so it overflows.
- `done` is asserted the cycle after the final handshake.
- `reset_n` low mid-burst or mid-drain: all state returns to reset values immediately. Partial data is lost and no `done` is generated.

## Structure
- Shared package:
  - `CL_W`=512
  - `CL_BEATS`=4
  - fill-state enum `collect_state_t` {IDLE, FILL}
  - these sit alongside existing common definitions (`complex_t`)
- Sub-module `cl_bank`: 4 x CL_W register bank with write-beat index, full flag, set/clear, and read-beat mux. It is instantiated twice.

## Test plan
- Single burst, `start` with base=0x100, num_bursts=1, beats D0..D3, `wr_ready`=1 -> `wr_valid` 4 cycles at addr 0x100..0x103 with data D0..D3, first valid one cycle after D3 in; `done` one cycle after the last handshake.
- Back-to-back bursts (8 consecutive `in_valid` cycles), `wr_ready` held low until both are in -> no error; 8 writes in order, addr base..base+7.
- Third burst while two banks full and `wr_ready`=0 -> `err_overflow`=1; only the first 8 lines are written; the 4th burst after draining is accepted normally.
- `in_valid` high 2 cycles then low -> `err_short`=1; no write issued; the next full burst is written at base+0.
- `wr_ready` toggling every other cycle -> `wr_addr`/`wr_data` stable while stalled; all lines delivered exactly once.
- `reset_n` asserted during drain beat 2 -> outputs at reset values; subsequent `start` and burst behave as in the first scenario.
